max7219_serial_tx: RTL and testbench

MAX7219_SERIAL_TX -- requirements
Module: max7219_serial_tx

---
 rtl/max7219_serial_tx.sv | 157 +++++++++++++++
 tb/tb_max7219_serial_tx.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_serial_tx.sv
// Serialises an eight-digit refresh (16-bit frames, MSB first) to a MAX7219 over CLK/DIN/LOAD.
// Define MAX7219_INIT_SEQ_EN to prefix every refresh with the five configuration frames.
module max7219_serial_tx #(
   parameter int          CLK_DIV   = 1,
   parameter int unsigned INTENSITY = 4'h8
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [63:0] i_digits,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_serial_clk,
   output logic        o_serial_dout,
   output logic        o_serial_load
);

`ifdef MAX7219_INIT_SEQ_EN
   localparam int NUM_FRAMES = 13;
   localparam int DIGIT_BASE = 5;
`else
   localparam int NUM_FRAMES = 8;
   localparam int DIGIT_BASE = 0;
`endif
   localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
   localparam logic [3:0] LAST_FRAME = 4'(NUM_FRAMES - 1);

   if (CLK_DIV < 1 || CLK_DIV > 255 || INTENSITY > 15) begin : g_bad_param
      $error("max7219_serial_tx: CLK_DIV must be 1..255 and INTENSITY 0..15");
   end

   typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, GAP, DONE} state_t;

   state_t      state;
   logic [63:0] snap;
   logic [3:0]  bit_cnt;
   logic [3:0]  frm_cnt;
   logic [7:0]  div_cnt;
   logic [3:0]  bit_nxt;
   logic [15:0] first_frame;
   logic [15:0] cur_frame;
   logic [15:0] next_frame;

   function automatic logic [15:0] frame_word(input logic [3:0] idx, input logic [63:0] dig);
      logic [15:0] word;
      word = 16'h0000;
`ifdef MAX7219_INIT_SEQ_EN
      case (idx)
         4'd0:    word = 16'h0C01;
         4'd1:    word = 16'h0900;
         4'd2:    word = {12'h0A0, 4'(INTENSITY)};
         4'd3:    word = 16'h0B07;
         4'd4:    word = 16'h0F00;
         default: word = 16'h0000;
      endcase
`endif
      for (int k = 0; k < 8; k++)
         if (idx == 4'(k + DIGIT_BASE)) word = {4'h0, 4'(k + 1), dig[8*k +: 8]};
      return word;
   endfunction

   // the first frame comes straight from i_digits because the snapshot is loaded on the same edge
   assign first_frame = frame_word(4'd0, i_digits);
   assign cur_frame   = frame_word(frm_cnt, snap);
   assign next_frame  = frame_word(frm_cnt + 4'd1, snap);
   assign bit_nxt     = bit_cnt - 4'd1;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state         <= IDLE;
         snap          <= '0;
         bit_cnt       <= '0;
         frm_cnt       <= '0;
         div_cnt       <= '0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_serial_clk  <= 1'b0;
         o_serial_dout <= 1'b0;
         o_serial_load <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  snap          <= i_digits;
                  frm_cnt       <= 4'd0;
                  bit_cnt       <= 4'd15;
                  div_cnt       <= DIV_RELOAD;
                  o_busy        <= 1'b1;
                  o_serial_clk  <= 1'b0;
                  o_serial_dout <= first_frame[15];
                  state         <= SHIFT_LO;
               end
            end
            SHIFT_LO: begin
               if (div_cnt == 8'd0) begin
                  div_cnt      <= DIV_RELOAD;
                  o_serial_clk <= 1'b1;
                  state        <= SHIFT_HI;
               end else begin
                  div_cnt <= div_cnt - 8'd1;
               end
            end
            SHIFT_HI: begin
               if (div_cnt == 8'd0) begin
                  div_cnt      <= DIV_RELOAD;
                  o_serial_clk <= 1'b0;
                  if (bit_cnt == 4'd0) begin
                     o_serial_dout <= 1'b0;
                     o_serial_load <= 1'b1;
                     state         <= LATCH;
                  end else begin
                     bit_cnt       <= bit_nxt;
                     o_serial_dout <= cur_frame[bit_nxt];
                     state         <= SHIFT_LO;
                  end
               end else begin
                  div_cnt <= div_cnt - 8'd1;
               end
            end
            LATCH: begin
               if (div_cnt == 8'd0) begin
                  div_cnt       <= DIV_RELOAD;
                  o_serial_load <= 1'b0;
                  state         <= GAP;
               end else begin
                  div_cnt <= div_cnt - 8'd1;
               end
            end
            GAP: begin
               if (div_cnt == 8'd0) begin
                  if (frm_cnt == LAST_FRAME) begin
                     o_done <= 1'b1;
                     state  <= DONE;
                  end else begin
                     frm_cnt       <= frm_cnt + 4'd1;
                     bit_cnt       <= 4'd15;
                     div_cnt       <= DIV_RELOAD;
                     o_serial_dout <= next_frame[15];
                     state         <= SHIFT_LO;
                  end
               end else begin
                  div_cnt <= div_cnt - 8'd1;
               end
            end
            DONE: begin
               // i_start in this cycle is dropped; only IDLE accepts a request
               o_busy  <= 1'b0;
               frm_cnt <= 4'd0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_max7219_serial_tx.sv
// Bench for max7219_serial_tx: two instances (CLK_DIV 1 and 3) decoded by a serial-stream monitor.
module tb_max7219_serial_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [63:0] digits;
   logic        busy [2];
   logic        done [2];
   logic        sclk [2];
   logic        dout [2];
   logic        load [2];

   int vecs = 0;
   int errs = 0;
   int cyc  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   max7219_serial_tx #(.CLK_DIV(1), .INTENSITY(8)) u_div1 (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_digits(digits),
      .o_busy(busy[0]), .o_done(done[0]), .o_serial_clk(sclk[0]),
      .o_serial_dout(dout[0]), .o_serial_load(load[0])
   );

   max7219_serial_tx #(.CLK_DIV(3), .INTENSITY(8)) u_div3 (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_digits(digits),
      .o_busy(busy[1]), .o_done(done[1]), .o_serial_clk(sclk[1]),
      .o_serial_dout(dout[1]), .o_serial_load(load[1])
   );

   function automatic int dv(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   // Monitor: decodes frames at LOAD rises and measures phase widths
   int          bits [2];
   int          hi_run [2];
   int          lo_run [2];
   int          ld_run [2];
   int          load_cnt [2];
   int          done_cnt [2];
   int          done_cyc [2];
   logic [15:0] shreg [2];
   logic        psclk [2];
   logic        pload [2];
   logic        pdone [2];
   logic        pdout [2];
   logic [15:0] rx0 [$];
   logic [15:0] rx1 [$];

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            bits[i] = 0; hi_run[i] = 0; lo_run[i] = 0; ld_run[i] = 0;
            psclk[i] = 1'b0; pload[i] = 1'b0; pdone[i] = 1'b0; pdout[i] = 1'b0;
         end else begin
            if (sclk[i] && !psclk[i]) begin
               if (bits[i] > 0) begin
                  vecs++;
                  if (lo_run[i] != dv(i)) begin
                     errs++;
                     $display("FAIL lo_phase dut%0d: got %0d cycles, expected %0d", i, lo_run[i], dv(i));
                  end
               end
               shreg[i] = {shreg[i][14:0], dout[i]};
               bits[i]++;
               hi_run[i] = 1;
            end else if (sclk[i]) begin
               hi_run[i]++;
            end
            if (!sclk[i] && psclk[i]) begin
               vecs++;
               if (hi_run[i] != dv(i)) begin
                  errs++;
                  $display("FAIL hi_phase dut%0d: got %0d cycles, expected %0d", i, hi_run[i], dv(i));
               end
               lo_run[i] = 1;
            end else if (!sclk[i]) begin
               lo_run[i]++;
            end
            if (sclk[i] && psclk[i]) begin
               vecs++;
               if (dout[i] !== pdout[i]) begin
                  errs++;
                  $display("FAIL dout_stable dut%0d: got %b, expected %b", i, dout[i], pdout[i]);
               end
            end
            if (load[i] && !pload[i]) begin
               vecs++;
               if (bits[i] != 16) begin
                  errs++;
                  $display("FAIL frame_len dut%0d: got %0d bits, expected 16", i, bits[i]);
               end
               vecs++;
               if ({sclk[i], dout[i]} !== 2'b00) begin
                  errs++;
                  $display("FAIL latch_lines dut%0d: got clk/din %b%b, expected 00", i, sclk[i], dout[i]);
               end
               if (i == 0) rx0.push_back(shreg[i]);
               else        rx1.push_back(shreg[i]);
               bits[i] = 0;
               load_cnt[i]++;
               ld_run[i] = 1;
            end else if (load[i]) begin
               ld_run[i]++;
            end
            if (!load[i] && pload[i]) begin
               vecs++;
               if (ld_run[i] != dv(i)) begin
                  errs++;
                  $display("FAIL load_width dut%0d: got %0d cycles, expected %0d", i, ld_run[i], dv(i));
               end
            end
            if (load[i]) begin
               vecs++;
               if (busy[i] !== 1'b1) begin
                  errs++;
                  $display("FAIL load_busy dut%0d: got busy %b, expected 1", i, busy[i]);
               end
            end
            if (done[i] && !pdone[i]) begin
               done_cnt[i]++;
               done_cyc[i] = cyc;
            end
            if (pdone[i]) begin
               vecs++;
               if (done[i] !== 1'b0) begin
                  errs++;
                  $display("FAIL done_width dut%0d: got done %b two cycles running, expected 0", i, done[i]);
               end
            end
            psclk[i] = sclk[i]; pload[i] = load[i]; pdone[i] = done[i]; pdout[i] = dout[i];
         end
      end
   end

   task automatic check_idle(input string nm);
      for (int i = 0; i < 2; i++) begin
         vecs++;
         if ({busy[i], done[i], sclk[i], dout[i], load[i]} !== 5'b00000) begin
            errs++;
            $display("FAIL %s dut%0d: got busy/done/clk/din/load %b%b%b%b%b, expected 00000",
                     nm, i, busy[i], done[i], sclk[i], dout[i], load[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; digits = '0;
      #1;
      check_idle("reset_async");
      repeat (3) @(posedge clk);
      #2;
      check_idle("reset_held");
      rst = 1'b0;
      @(posedge clk);
      #2;
      check_idle("after_reset");
   endtask

   // Full refresh against the frame list derived from the display protocol
   task automatic run_refresh(input logic [63:0] dg, input bit disturb, input bit release_rst, input string nm);
      logic [15:0] exp [$];
      logic [15:0] got;
      int n, s_cyc, guard;
      int l0 [2];
      int d0 [2];
`ifdef MAX7219_INIT_SEQ_EN
      exp.push_back(16'h0C01);
      exp.push_back(16'h0900);
      exp.push_back(16'h0A08);
      exp.push_back(16'h0B07);
      exp.push_back(16'h0F00);
`endif
      for (int k = 1; k <= 8; k++) exp.push_back({4'h0, 4'(k), dg[8*(k-1) +: 8]});
      n = exp.size();
      rx0.delete();
      rx1.delete();
      for (int i = 0; i < 2; i++) begin
         l0[i] = load_cnt[i];
         d0[i] = done_cnt[i];
      end
      if (!release_rst) begin
         @(posedge clk);
         #2;
      end
      rst = 1'b0; start = 1'b1; digits = dg; s_cyc = cyc;
      @(posedge clk);
      #2;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         vecs++;
         if (busy[i] !== 1'b1) begin
            errs++;
            $display("FAIL %s_busy_rise dut%0d: got %b, expected 1", nm, i, busy[i]);
         end
      end
      guard = 0;
      while ((done_cnt[0] == d0[0] || done_cnt[1] == d0[1]) && guard < 20000) begin
         if (disturb && guard == 100) begin start = 1'b1; digits = ~dg; end
         if (disturb && guard == 101) start = 1'b0;
         @(posedge clk);
         #2;
         guard++;
      end
      vecs++;
      if (guard >= 20000) begin
         errs++;
         $display("FAIL %s_timeout: got no o_done within %0d cycles, expected one", nm, guard);
      end
      for (int i = 0; i < 2; i++) begin
         vecs++;
         if (done_cyc[i] - s_cyc != n * 34 * dv(i) + 1) begin
            errs++;
            $display("FAIL %s_latency dut%0d: got %0d cycles, expected %0d", nm, i, done_cyc[i] - s_cyc, n * 34 * dv(i) + 1);
         end
         vecs++;
         if (load_cnt[i] - l0[i] != n) begin
            errs++;
            $display("FAIL %s_loads dut%0d: got %0d, expected %0d", nm, i, load_cnt[i] - l0[i], n);
         end
         for (int k = 0; k < n; k++) begin
            got = 16'hxxxx;
            if (i == 0 && k < rx0.size()) got = rx0[k];
            if (i == 1 && k < rx1.size()) got = rx1[k];
            vecs++;
            if (got !== exp[k]) begin
               errs++;
               $display("FAIL %s_frame%0d dut%0d: got %h, expected %h", nm, k, i, got, exp[k]);
            end
         end
      end
      repeat (20) @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
         vecs++;
         if (done_cnt[i] - d0[i] != 1 || busy[i] !== 1'b0) begin
            errs++;
            $display("FAIL %s_single_run dut%0d: got %0d dones busy %b, expected 1 done busy 0",
                     nm, i, done_cnt[i] - d0[i], busy[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int l0, lr0, lr1, dr0, dr1, guard;
      l0 = load_cnt[0];
      @(posedge clk);
      #2;
      start = 1'b1; digits = {$urandom, $urandom};
      @(posedge clk);
      #2;
      start = 1'b0;
      guard = 0;
      while (load_cnt[0] - l0 < 2 && guard < 2000) begin
         @(posedge clk);
         #2;
         guard++;
      end
      vecs++;
      if (guard >= 2000) begin
         errs++;
         $display("FAIL reset_mid_timeout: got %0d loads, expected 2", load_cnt[0] - l0);
      end
      repeat (10) @(posedge clk);
      #4;
      lr0 = load_cnt[0]; lr1 = load_cnt[1]; dr0 = done_cnt[0]; dr1 = done_cnt[1];
      rst = 1'b1;
      #1;
      check_idle("reset_mid_async");
      repeat (3) @(posedge clk);
      #2;
      vecs++;
      if (load_cnt[0] != lr0 || load_cnt[1] != lr1 || done_cnt[0] != dr0 || done_cnt[1] != dr1) begin
         errs++;
         $display("FAIL reset_mid_abort: got load/done deltas %0d %0d %0d %0d, expected 0 0 0 0",
                  load_cnt[0] - lr0, load_cnt[1] - lr1, done_cnt[0] - dr0, done_cnt[1] - dr1);
      end
      run_refresh({$urandom, $urandom}, 1'b0, 1'b1, "post_reset");
   endtask

   task automatic test_start_at_done();
      int d0, d1, guard;
      d0 = done_cnt[0]; d1 = done_cnt[1];
      @(posedge clk);
      #2;
      start = 1'b1; digits = {$urandom, $urandom};
      @(posedge clk);
      #2;
      start = 1'b0;
      guard = 0;
      while (done_cnt[0] == d0 && guard < 5000) begin
         @(posedge clk);
         #2;
         guard++;
      end
      vecs++;
      if (done[0] !== 1'b1) begin
         errs++;
         $display("FAIL done_cycle: got done %b, expected 1", done[0]);
      end
      start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
      vecs++;
      if ({busy[0], done[0]} !== 2'b00) begin
         errs++;
         $display("FAIL start_at_done: got busy/done %b%b, expected 00", busy[0], done[0]);
      end
      guard = 0;
      while (done_cnt[1] == d1 && guard < 5000) begin
         @(posedge clk);
         #2;
         guard++;
      end
      repeat (20) @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
         vecs++;
         if (busy[i] !== 1'b0 || done_cnt[i] != (i == 0 ? d0 : d1) + 1) begin
            errs++;
            $display("FAIL start_at_done_idle dut%0d: got busy %b dones %0d, expected busy 0 dones 1",
                     i, busy[i], done_cnt[i] - (i == 0 ? d0 : d1));
         end
      end
   endtask

   initial begin
      test_reset();
      run_refresh(64'h0706050403020100, 1'b0, 1'b0, "ordered");
      for (int r = 0; r < 3; r++) run_refresh({$urandom, $urandom}, 1'b0, 1'b0, "random");
      run_refresh({$urandom, $urandom}, 1'b1, 1'b0, "retrigger");
      test_reset_mid();
      test_start_at_done();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
